// File: rtl/codec_stream_reader.sv
// rtl/codec_stream_reader.sv - ping-pong byte buffer reader assembling PCM frames for the I2S master
module codec_stream_reader #(
    parameter int BUFFER_ADDR_BITS  = 9,
    parameter int RAM_WAIT_STATES   = 1,
    parameter int DATA_BITS         = 24,
    parameter int UNDERRUN_CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_stereo_i,
    input  logic                         cfg_16bit_i,
    input  logic                         pause_i,
    output logic                         buff_sel_o,
    output logic [BUFFER_ADDR_BITS-1:0]  buff_addr_o,
    input  logic [7:0]                   buff_data_i,
    input  logic                         buff_filled_i,
    output logic                         buff_empty_o,
    input  logic                         buff_empty_ack_i,
    output logic [DATA_BITS-1:0]         frame_l_o,
    output logic [DATA_BITS-1:0]         frame_r_o,
    output logic                         frame_valid_o,
    input  logic                         frame_ready_i,
    output logic                         underrun_o,
    output logic [UNDERRUN_CNT_BITS-1:0] underrun_cnt_o
);
    typedef enum logic [1:0] {S_WAIT_FILL, S_READ, S_EMIT, S_PAUSE} state_t;

    localparam logic [2:0] WAIT_MAX = 3'(RAM_WAIT_STATES);
    localparam int SHIFT16 = DATA_BITS - 16;
    localparam int SHIFT8  = DATA_BITS - 8;

    state_t                         state_q, state_d;
    logic                           sel_q, sel_d;
    logic [BUFFER_ADDR_BITS-1:0]    addr_q, addr_d;
    logic                           empty_q, empty_d;
    logic [DATA_BITS-1:0]           frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic                           valid_q, valid_d;
    logic                           underrun_q, underrun_d;
    logic [UNDERRUN_CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [1:0]                     byte_idx_q, byte_idx_d;
    logic [2:0]                     wait_q, wait_d;
    logic                           ended_q, ended_d;
    logic                           stereo_q, stereo_d, b16_q, b16_d;
    logic [7:0]                     byte0_q, byte0_d, byte1_q, byte1_d, byte2_q, byte2_d;
    logic                           swap;
    logic [1:0]                     last_idx;

    function automatic logic [DATA_BITS-1:0] conv8(input logic [7:0] b);
        return DATA_BITS'({~b[7], b[6:0]}) << SHIFT8;
    endfunction

    function automatic logic [DATA_BITS-1:0] conv16(input logic [7:0] hi, input logic [7:0] lo);
        return DATA_BITS'({hi, lo}) << SHIFT16;
    endfunction

    // Index of the final byte in a frame: 3, 1, 1 or 0.
    assign last_idx = {stereo_q & b16_q, stereo_q | b16_q};

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        empty_d    = empty_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        valid_d    = valid_q;
        underrun_d = 1'b0;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        wait_d     = wait_q;
        ended_d    = ended_q;
        stereo_d   = stereo_q;
        b16_d      = b16_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
        byte2_d    = byte2_q;
        swap       = 1'b0;

        case (state_q)
            S_WAIT_FILL: begin
                if (buff_filled_i) begin
                    swap     = 1'b1;
                    stereo_d = cfg_stereo_i;
                    b16_d    = cfg_16bit_i;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (wait_q == WAIT_MAX) begin
                    wait_d = 3'd0;
                    case (byte_idx_q)
                        2'd0:    byte0_d = buff_data_i;
                        2'd1:    byte1_d = buff_data_i;
                        2'd2:    byte2_d = buff_data_i;
                        default: ;
                    endcase
                    if (addr_q == {BUFFER_ADDR_BITS{1'b1}}) begin
                        ended_d = 1'b1;
                    end else begin
                        addr_d = addr_q + BUFFER_ADDR_BITS'(1);
                    end
                    if (byte_idx_q == last_idx) begin
                        byte_idx_d = 2'd0;
                        valid_d    = 1'b1;
                        state_d    = S_EMIT;
                        // Final byte comes straight from the RAM port; earlier ones from capture regs.
                        case ({stereo_q, b16_q})
                            2'b11: begin
                                frame_l_d = conv16(byte1_q, byte0_q);
                                frame_r_d = conv16(buff_data_i, byte2_q);
                            end
                            2'b10: begin
                                frame_l_d = conv8(byte0_q);
                                frame_r_d = conv8(buff_data_i);
                            end
                            2'b01: begin
                                frame_l_d = conv16(buff_data_i, byte0_q);
                                frame_r_d = conv16(buff_data_i, byte0_q);
                            end
                            default: begin
                                frame_l_d = conv8(buff_data_i);
                                frame_r_d = conv8(buff_data_i);
                            end
                        endcase
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_EMIT: begin
                if (valid_q && frame_ready_i) begin
                    valid_d = 1'b0;
                    if (ended_q && buff_filled_i) begin
                        swap    = 1'b1;
                        state_d = pause_i ? S_PAUSE : S_READ;
                    end else if (ended_q) begin
                        underrun_d = 1'b1;
                        if (cnt_q != {UNDERRUN_CNT_BITS{1'b1}}) begin
                            cnt_d = cnt_q + UNDERRUN_CNT_BITS'(1);
                        end
                        state_d = S_WAIT_FILL;
                    end else begin
                        state_d = pause_i ? S_PAUSE : S_READ;
                    end
                end
            end
            S_PAUSE: begin
                if (!pause_i) begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_WAIT_FILL;
        endcase

        if (buff_empty_ack_i) begin
            empty_d = 1'b0;
        end
        // A swap in the same cycle as an ack must leave the new buffer flagged empty.
        if (swap) begin
            sel_d      = ~sel_q;
            addr_d     = '0;
            empty_d    = 1'b1;
            byte_idx_d = 2'd0;
            wait_d     = 3'd0;
            ended_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_WAIT_FILL;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            empty_q    <= 1'b1;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
            byte_idx_q <= 2'd0;
            wait_q     <= 3'd0;
            ended_q    <= 1'b0;
            stereo_q   <= 1'b0;
            b16_q      <= 1'b0;
            byte0_q    <= 8'd0;
            byte1_q    <= 8'd0;
            byte2_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            empty_q    <= empty_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            wait_q     <= wait_d;
            ended_q    <= ended_d;
            stereo_q   <= stereo_d;
            b16_q      <= b16_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
            byte2_q    <= byte2_d;
        end
    end

    assign buff_sel_o     = sel_q;
    assign buff_addr_o    = addr_q;
    assign buff_empty_o   = empty_q;
    assign frame_l_o      = frame_l_q;
    assign frame_r_o      = frame_r_q;
    assign frame_valid_o  = valid_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = cnt_q;
endmodule
